mem_resp: RTL and testbench



---
 rtl/mem_resp_pkg.sv | 14 +
 rtl/mem_resp_ram.sv | 30 +++
 rtl/mem_resp.sv | 144 ++++++++++++++
 tb/tb_mem_resp.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder: word width, wait-counter
// width and the control FSM state encoding.
package mem_resp_pkg;

  localparam int MR_RW    = 16;  // default word width
  localparam int MR_CNT_W = 4;   // wait counter holds 0..15

  typedef enum logic [1:0] {
    MR_IDLE = 2'd0,
    MR_WAIT = 2'd1,
    MR_ACK  = 2'd2
  } mr_state_e;

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port synchronous word RAM, DEPTH x RW, with a registered read.
// The read register updates every cycle from whatever address is presented,
// so the owner steers the address to get the word it wants on the next cycle.
// Kept as its own module so it can be replaced by a hard macro.
module mem_resp_ram #(
  parameter int RW    = 16,
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [RW-1:0] i_wdata,
  output logic [RW-1:0] o_rdata
);

  logic [RW-1:0] mem_q [DEPTH];
  logic [RW-1:0] rdata_q;

  // Storage array write port and registered read port (read-before-write).
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_addr] <= i_wdata;
    end
    rdata_q <= mem_q[i_addr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/mem_resp.sv
// Memory responder: target side of the data-memory req/ack interface.
// A held request is accepted in IDLE, optionally waits WAIT_CYCLES cycles,
// then completes with a one-cycle ack. Out-of-range accesses complete
// normally with zero read data, perform no write, and set a sticky error.
//
// Handshake: i_mem_req is a level held by the initiator until the ack cycle;
// the request is accepted on a clock edge where the FSM is IDLE and
// i_mem_req=1. o_mem_ack is high for exactly one cycle; i_mem_req seen during
// that cycle belongs to the finishing transaction, and a request still high
// in the following IDLE cycle is a new transaction.
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int RW          = MR_RW,
  parameter int DEPTH       = 256,
  parameter int BASE_ADDR   = 0,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_mem_req,
  input  logic [RW-1:0] i_mem_addr,
  input  logic [RW-1:0] i_mem_data,
  input  logic          i_mem_we,
  output logic          o_mem_ack,
  output logic [RW-1:0] o_mem_data,
  output logic          o_err,
  output logic          o_busy,
  output mr_state_e     o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [MR_CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? MR_CNT_W'(WAIT_CYCLES - 1) : '0;

  mr_state_e           state_q, state_d;
  logic [MR_CNT_W-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [AW-1:0]       idx_q;
  logic [RW-1:0]       wdata_q;
  logic                we_q;
  logic                inr_q;

  logic [RW-1:0]       in_off;
  logic                in_range;
  logic [AW-1:0]       in_idx;
  logic                accept;
  logic                ram_we;
  logic [AW-1:0]       ram_addr;
  logic [RW-1:0]       ram_rdata;

  // Offset from the base wraps modulo 2^RW, so addresses below the base
  // land far above DEPTH and are rejected by the same compare.
  assign in_off   = i_mem_addr - RW'(BASE_ADDR);
  assign in_range = ({1'b0, in_off} < (RW+1)'(DEPTH));
  assign in_idx   = in_off[AW-1:0];
  assign accept   = (state_q == MR_IDLE) && i_mem_req;

  // In IDLE the RAM looks at the incoming address so a zero-wait read has
  // its data registered by the ack cycle; afterwards it holds the latched
  // index, which is also the write address in ACK.
  assign ram_addr = (state_q == MR_IDLE) ? in_idx : idx_q;
  assign ram_we   = (state_q == MR_ACK) && we_q && inr_q && !i_rst;

  mem_resp_ram #(
    .RW    (RW),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (ram_we),
    .i_addr  (ram_addr),
    .i_wdata (wdata_q),
    .o_rdata (ram_rdata)
  );

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= MR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MR_IDLE: if (i_mem_req) state_d = (WAIT_CYCLES > 0) ? MR_WAIT : MR_ACK;
      MR_WAIT: if (cnt_q == '0) state_d = MR_ACK;
      MR_ACK:  state_d = MR_IDLE;
      default: state_d = MR_IDLE;
    endcase
  end

  // FSM outputs; read data is forced to zero outside a good read ack.
  always_comb begin
    o_mem_ack  = (state_q == MR_ACK);
    o_busy     = (state_q != MR_IDLE);
    o_mem_data = '0;
    if ((state_q == MR_ACK) && !we_q && inr_q) begin
      o_mem_data = ram_rdata;
    end
  end

  // Wait counter and sticky error next-state.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (accept) begin
      cnt_d = CNT_LOAD;
    end else if ((state_q == MR_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if ((state_q == MR_ACK) && !inr_q) begin
      err_d = 1'b1;
    end
  end

  // Counter, error flag and request capture registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      inr_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (accept) begin
        idx_q   <= in_idx;
        wdata_q <= i_mem_data;
        we_q    <= i_mem_we;
        inr_q   <= in_range;
      end
    end
  end

  assign o_err       = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mem_resp.sv
// Bench for mem_resp. Three instances:
//   0: WAIT_CYCLES=1, BASE_ADDR=0      (directed + table)
//   1: WAIT_CYCLES=1, BASE_ADDR=0x0100 (range/wrap and sticky error)
//   2: WAIT_CYCLES=0, BASE_ADDR=0      (random sweep against a memory model)
// Inputs are driven and outputs sampled on the falling edge.
module tb_mem_resp;
  import mem_resp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic        req   [3];
  logic        we    [3];
  logic [15:0] addr  [3];
  logic [15:0] wdata [3];
  logic        ack   [3];
  logic [15:0] rdata [3];
  logic        err   [3];
  logic        busy  [3];
  mr_state_e   st    [3];

  mem_resp #(.RW(16), .DEPTH(256), .BASE_ADDR(0), .WAIT_CYCLES(1)) dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_mem_req(req[0]), .i_mem_addr(addr[0]),
    .i_mem_data(wdata[0]), .i_mem_we(we[0]), .o_mem_ack(ack[0]),
    .o_mem_data(rdata[0]), .o_err(err[0]), .o_busy(busy[0]), .o_dbg_state(st[0]));

  mem_resp #(.RW(16), .DEPTH(256), .BASE_ADDR(16'h0100), .WAIT_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_mem_req(req[1]), .i_mem_addr(addr[1]),
    .i_mem_data(wdata[1]), .i_mem_we(we[1]), .o_mem_ack(ack[1]),
    .o_mem_data(rdata[1]), .o_err(err[1]), .o_busy(busy[1]), .o_dbg_state(st[1]));

  mem_resp #(.RW(16), .DEPTH(256), .BASE_ADDR(0), .WAIT_CYCLES(0)) dut2 (
    .i_clk(clk), .i_rst(rst[2]), .i_mem_req(req[2]), .i_mem_addr(addr[2]),
    .i_mem_data(wdata[2]), .i_mem_we(we[2]), .o_mem_ack(ack[2]),
    .o_mem_data(rdata[2]), .o_err(err[2]), .o_busy(busy[2]), .o_dbg_state(st[2]));

  // ---------------- scoreboard / counters ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present a request and wait (bounded) for its ack. lat counts falling
  // edges from the drive point to the ack cycle; 0 means no ack arrived.
  // Read data must be zero in every non-ack cycle seen on the way.
  task automatic txn(input int d, input logic w, input logic [15:0] a,
                     input logic [15:0] wd, output logic [15:0] rd,
                     output int lat);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    lat = 0;
    rd  = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ack[d]) begin
        lat = k;
        rd  = rdata[d];
        chk("busy_in_ack", busy[d], 1);
        break;
      end
      chk("data_outside_ack", rdata[d], 0);
    end
  endtask

  // Drop the request after an ack and confirm the pulse was single-cycle.
  task automatic release_req(input int d);
    req[d] = 1'b0;
    @(negedge clk);
    chk("ack_single_cycle", ack[d], 0);
    chk("busy_after_ack", busy[d], 0);
    chk("data_after_ack", rdata[d], 0);
  endtask

  // No two consecutive ack cycles on the zero-wait instance.
  logic prev_ack2 = 1'b0;
  always @(negedge clk) begin
    if (ack[2]) chk("ack2_consecutive", prev_ack2, 0);
    prev_ack2 = ack[2];
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [15:0] wd;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[11];

  // Reference memory for the random sweep.
  logic [15:0] model_mem [256];
  bit          model_ok  [256];

  logic [15:0] rd;
  int          lat;

  initial begin
    tbl[0]  = '{1'b1, 16'h0000, 16'hA5A5, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 16'h00FF, 16'h5A5A, 16'h0000, 1'b0};
    tbl[2]  = '{1'b1, 16'h0080, 16'h0001, 16'h0000, 1'b0};
    tbl[3]  = '{1'b0, 16'h0000, 16'h0000, 16'hA5A5, 1'b0};
    tbl[4]  = '{1'b0, 16'h00FF, 16'h0000, 16'h5A5A, 1'b0};
    tbl[5]  = '{1'b1, 16'h0080, 16'hFFFF, 16'h0000, 1'b0};
    tbl[6]  = '{1'b0, 16'h0080, 16'h0000, 16'hFFFF, 1'b0};
    tbl[7]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
    tbl[8]  = '{1'b1, 16'h0100, 16'hDEAD, 16'h0000, 1'b1};
    tbl[9]  = '{1'b0, 16'h0000, 16'h0000, 16'hA5A5, 1'b1};
    tbl[10] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
    end

    // ---- reset state ----
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_ack",   ack[d],   0);
      chk("rst_data",  rdata[d], 0);
      chk("rst_err",   err[d],   0);
      chk("rst_busy",  busy[d],  0);
      chk("rst_state", st[d],    MR_IDLE);
    end
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    @(negedge clk);

    // ---- write, read-back, back-to-back on dut0 ----
    txn(0, 1'b1, 16'h0010, 16'hBEEF, rd, lat);
    chk("wr_latency", lat, 2);
    chk("wr_data", rd, 0);
    release_req(0);
    chk("wr_err", err[0], 0);

    txn(0, 1'b0, 16'h0010, 16'h0000, rd, lat);
    chk("rd_latency", lat, 2);
    chk("rd_data", rd, 16'hBEEF);
    // keep req high: next request follows directly
    txn(0, 1'b1, 16'h0011, 16'h1234, rd, lat);
    chk("b2b_wr_spacing", lat, 3);
    txn(0, 1'b0, 16'h0011, 16'h0000, rd, lat);
    chk("b2b_rd_spacing", lat, 3);
    chk("b2b_rd_data", rd, 16'h1234);
    release_req(0);

    // ---- table-driven vectors on dut0 (index edges, overwrite, out-of-range) ----
    for (int i = 0; i < 11; i++) begin
      txn(0, tbl[i].w, tbl[i].a, tbl[i].wd, rd, lat);
      chk("tbl_latency", lat, 2);
      chk("tbl_data", rd, tbl[i].exp_rd);
      release_req(0);
      chk("tbl_err", err[0], tbl[i].exp_err);
    end

    // ---- reset during wait: write abandoned ----
    txn(0, 1'b1, 16'h0020, 16'h1111, rd, lat);
    release_req(0);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0020; wdata[0] = 16'h5555;
    @(negedge clk);
    chk("pre_rst_state", st[0], MR_WAIT);
    rst[0] = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    chk("rst_mid_ack",   ack[0],  0);
    chk("rst_mid_state", st[0],   MR_IDLE);
    chk("rst_mid_busy",  busy[0], 0);
    chk("rst_mid_err",   err[0],  0);
    rst[0] = 1'b0;
    @(negedge clk);
    chk("rst_mid_no_late_ack", ack[0], 0);
    txn(0, 1'b0, 16'h0020, 16'h0000, rd, lat);
    chk("rst_mid_readback", rd, 16'h1111);
    release_req(0);

    // ---- reset in the ack cycle: write not committed ----
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0020; wdata[0] = 16'h7777;
    repeat (2) @(negedge clk);
    chk("ack_before_rst", ack[0], 1);
    rst[0] = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b0;
    txn(0, 1'b0, 16'h0020, 16'h0000, rd, lat);
    chk("rst_ack_readback", rd, 16'h1111);
    release_req(0);

    // ---- request dropped early: still completes ----
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0030; wdata[0] = 16'h3030;
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    chk("drop_still_acked", ack[0], 1);
    @(negedge clk);
    chk("drop_single_ack", ack[0], 0);
    txn(0, 1'b0, 16'h0030, 16'h0000, rd, lat);
    chk("drop_readback", rd, 16'h3030);
    release_req(0);
    chk("drop_no_err", err[0], 0);

    // ---- dut1: BASE_ADDR=0x0100, wrap check and sticky error ----
    txn(1, 1'b1, 16'h0100, 16'hCAFE, rd, lat);
    release_req(1);
    chk("b1_inrange_err", err[1], 0);
    txn(1, 1'b0, 16'h00FF, 16'h0000, rd, lat);
    chk("b1_wrap_lat", lat, 2);
    chk("b1_wrap_data", rd, 0);
    release_req(1);
    chk("b1_wrap_err", err[1], 1);
    txn(1, 1'b0, 16'h0100, 16'h0000, rd, lat);
    chk("b1_good_data", rd, 16'hCAFE);
    release_req(1);
    chk("b1_err_sticky", err[1], 1);
    txn(1, 1'b1, 16'h01FF, 16'h0F0F, rd, lat);
    release_req(1);
    txn(1, 1'b0, 16'h01FF, 16'h0000, rd, lat);
    chk("b1_top_data", rd, 16'h0F0F);
    release_req(1);
    txn(1, 1'b0, 16'h0200, 16'h0000, rd, lat);
    chk("b1_above_data", rd, 0);
    release_req(1);
    chk("b1_err_sticky2", err[1], 1);

    // ---- dut2: WAIT_CYCLES=0 random sweep against the memory model ----
    for (int i = 0; i < 256; i++) model_ok[i] = 1'b0;
    begin
      bit held;
      held = 1'b0;
      for (int i = 0; i < 100; i++) begin
        logic [15:0] a, wd;
        logic        w;
        a  = 16'($urandom_range(0, 255));
        wd = 16'($urandom);
        w  = ($urandom_range(0, 1) == 1) || !model_ok[a[7:0]];
        txn(2, w, a, wd, rd, lat);
        chk("sweep_latency", lat, held ? 2 : 1);
        if (w) begin
          chk("sweep_wr_data", rd, 0);
          model_mem[a[7:0]] = wd;
          model_ok[a[7:0]]  = 1'b1;
        end else begin
          chk("sweep_rd_data", rd, model_mem[a[7:0]]);
        end
        held = ($urandom_range(0, 1) == 1);
        if (!held) release_req(2);
      end
      if (held) release_req(2);
    end
    chk("sweep_err", err[2], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
